// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid buffer between the EX stage and MEM; upstream ready is a pure flop output.
// Optional arithmetic-exception trap path is enabled with `define EX_MEM_EXC_TRAP_EN.
module ex_mem_skid #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_result,
  input  logic                      in_overflow,
  input  logic                      in_underflow,
  input  logic [3:0]                in_flag,
  input  logic [DATA_WIDTH-1:0]     in_next_addr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic                      in_mem_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic [3:0]                out_flag,
  output logic [DATA_WIDTH-1:0]     out_next_addr,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic                      out_mem_write
`ifdef EX_MEM_EXC_TRAP_EN
  ,
  output logic                      exc_valid,
  output logic [DATA_WIDTH-1:0]     exc_epc
`endif
);

  localparam int unsigned FLAG_WIDTH = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic                      overflow;
    logic                      underflow;
    logic [FLAG_WIDTH-1:0]     flag;
    logic [DATA_WIDTH-1:0]     next_addr;
    logic [DATA_WIDTH-1:0]     pc;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  beat_t  out_pl_q, out_pl_d;
  beat_t  skid_pl_q, skid_pl_d;
  beat_t  in_pl;
  logic   accept;
  logic   deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  // Incoming beat; a faulting arithmetic op must not write back or touch memory when trapping.
  always_comb begin
    in_pl           = '0;
    in_pl.result    = in_result;
    in_pl.overflow  = in_overflow;
    in_pl.underflow = in_underflow;
    in_pl.flag      = in_flag;
    in_pl.next_addr = in_next_addr;
    in_pl.pc        = in_pc;
    in_pl.rd        = in_rd;
    in_pl.reg_write = in_reg_write;
    in_pl.mem_read  = in_mem_read;
    in_pl.mem_write = in_mem_write;
`ifdef EX_MEM_EXC_TRAP_EN
    if (in_overflow | in_underflow) begin
      in_pl.reg_write = 1'b0;
      in_pl.mem_read  = 1'b0;
      in_pl.mem_write = 1'b0;
    end
`endif
  end

  // Occupancy FSM and payload steering; flush wins over any accept/deliver.
  always_comb begin
    state_d   = state_q;
    out_pl_d  = out_pl_q;
    skid_pl_d = skid_pl_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_pl_d = in_pl;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          out_pl_d = in_pl;
        end else if (accept) begin
          skid_pl_d = in_pl;
          state_d   = ST_FULL;
        end else if (deliver) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          out_pl_d = skid_pl_q;
          state_d  = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (flush) begin
      state_d   = ST_EMPTY;
      out_pl_d  = out_pl_q;
      skid_pl_d = skid_pl_q;
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_pl_q    <= '0;
      skid_pl_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_pl_q    <= out_pl_d;
      skid_pl_q   <= skid_pl_d;
    end
  end

`ifdef EX_MEM_EXC_TRAP_EN
  logic                  exc_valid_q, exc_valid_d;
  logic [DATA_WIDTH-1:0] exc_epc_q, exc_epc_d;

  // One-cycle pulse per accepted faulting beat; EPC held until the next exception.
  always_comb begin
    exc_valid_d = accept & ~flush & (in_overflow | in_underflow);
    exc_epc_d   = exc_epc_q;
    if (exc_valid_d) begin
      exc_epc_d = in_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      exc_valid_q <= 1'b0;
      exc_epc_q   <= '0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_epc_q   <= exc_epc_d;
    end
  end

  assign exc_valid = exc_valid_q;
  assign exc_epc   = exc_epc_q;
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_pl_q.result;
  assign out_overflow  = out_pl_q.overflow;
  assign out_underflow = out_pl_q.underflow;
  assign out_flag      = out_pl_q.flag;
  assign out_next_addr = out_pl_q.next_addr;
  assign out_pc        = out_pl_q.pc;
  assign out_rd        = out_pl_q.rd;
  assign out_reg_write = out_pl_q.reg_write;
  assign out_mem_read  = out_pl_q.mem_read;
  assign out_mem_write = out_pl_q.mem_write;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: randomized bench for ex_mem_skid against a FIFO-of-beats reference model.
module tb_ex_mem_skid;

  localparam int unsigned DW  = 32;
  localparam int unsigned RAW = 5;

  typedef struct packed {
    logic [DW-1:0]  result;
    logic           overflow;
    logic           underflow;
    logic [3:0]     flag;
    logic [DW-1:0]  next_addr;
    logic [DW-1:0]  pc;
    logic [RAW-1:0] rd;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset, flush, in_valid, in_ready;
  logic [DW-1:0]  in_result, in_next_addr, in_pc;
  logic           in_overflow, in_underflow;
  logic [3:0]     in_flag;
  logic [RAW-1:0] in_rd;
  logic           in_reg_write, in_mem_read, in_mem_write;
  logic           out_valid, out_ready;
  logic [DW-1:0]  out_result, out_next_addr, out_pc;
  logic           out_overflow, out_underflow;
  logic [3:0]     out_flag;
  logic [RAW-1:0] out_rd;
  logic           out_reg_write, out_mem_read, out_mem_write;
`ifdef EX_MEM_EXC_TRAP_EN
  logic           exc_valid;
  logic [DW-1:0]  exc_epc;
  logic           exp_exc = 1'b0;
  logic [DW-1:0]  exp_epc = '0;
`endif

  always #5 clock = ~clock;

  ex_mem_skid #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RAW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .in_flag(in_flag), .in_next_addr(in_next_addr), .in_pc(in_pc), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_flag(out_flag), .out_next_addr(out_next_addr), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
`ifdef EX_MEM_EXC_TRAP_EN
    , .exc_valid(exc_valid), .exc_epc(exc_epc)
`endif
  );

  beat_t q[$];
  int    total = 0;
  int    bad = 0;
  int    delivered = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.result    = $urandom;
    b.overflow  = ($urandom_range(0, 5) == 0);
    b.underflow = ($urandom_range(0, 5) == 0);
    b.flag      = 4'($urandom);
    b.next_addr = $urandom;
    b.pc        = $urandom;
    b.rd        = RAW'($urandom);
    b.reg_write = 1'($urandom);
    b.mem_read  = 1'($urandom);
    b.mem_write = 1'($urandom);
    return b;
  endfunction

  function automatic beat_t dut_beat();
    beat_t d;
    d.result    = out_result;
    d.overflow  = out_overflow;
    d.underflow = out_underflow;
    d.flag      = out_flag;
    d.next_addr = out_next_addr;
    d.pc        = out_pc;
    d.rd        = out_rd;
    d.reg_write = out_reg_write;
    d.mem_read  = out_mem_read;
    d.mem_write = out_mem_write;
    return d;
  endfunction

  // Drive one cycle, advance the model across the edge, then compare at the falling edge.
  task automatic cycle(input logic v, input beat_t b, input logic ordy, input logic fl,
                       input logic rst, output logic acc);
    logic  dlv;
    beat_t s;
    in_valid = v; out_ready = ordy; flush = fl; reset = rst;
    in_result = b.result; in_overflow = b.overflow; in_underflow = b.underflow;
    in_flag = b.flag; in_next_addr = b.next_addr; in_pc = b.pc; in_rd = b.rd;
    in_reg_write = b.reg_write; in_mem_read = b.mem_read; in_mem_write = b.mem_write;
    acc = 1'b0;
    if (rst) begin
      q.delete();
`ifdef EX_MEM_EXC_TRAP_EN
      exp_exc = 1'b0; exp_epc = '0;
`endif
    end else if (fl) begin
      q.delete();
`ifdef EX_MEM_EXC_TRAP_EN
      exp_exc = 1'b0;
`endif
    end else begin
      dlv = (q.size() > 0) && ordy;
      acc = v && (q.size() < 2);
      if (dlv) begin
        void'(q.pop_front());
        delivered++;
      end
      if (acc) begin
        s = b;
`ifdef EX_MEM_EXC_TRAP_EN
        if (b.overflow || b.underflow) begin
          s.reg_write = 1'b0; s.mem_read = 1'b0; s.mem_write = 1'b0;
        end
`endif
        q.push_back(s);
      end
`ifdef EX_MEM_EXC_TRAP_EN
      exp_exc = acc && (b.overflow || b.underflow);
      if (exp_exc) exp_epc = b.pc;
`endif
    end
    @(negedge clock);
    check("out_valid", 128'(out_valid), 128'(q.size() > 0));
    check("in_ready", 128'(in_ready), 128'(q.size() < 2));
    if (q.size() > 0) check("payload", 128'(dut_beat()), 128'(q[0]));
`ifdef EX_MEM_EXC_TRAP_EN
    check("exc_valid", 128'(exc_valid), 128'(exp_exc));
    check("exc_epc", 128'(exc_epc), 128'(exp_epc));
`endif
  endtask

  task automatic check_zero(input string tag);
    check(tag, 128'(dut_beat()), 128'(0));
    check({tag, "_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_ready"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    beat_t b;
    logic  acc;
    int    d0, n, cyc;

    // Reset, then a single beat with MEM ready.
    cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b1, acc);
    check_zero("reset_init");
    b = rand_beat(); b.result = 32'h0000_00AA; b.rd = 5'd3; b.overflow = 0; b.underflow = 0;
    cycle(1'b1, b, 1'b1, 1'b0, 1'b0, acc);
    check("t1_result", 128'(out_result), 128'(32'hAA));
    check("t1_rd", 128'(out_rd), 128'(3));
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0, acc);

    // Stall fills both entries; third beat is held until space frees up.
    d0 = delivered;
    b = rand_beat(); b.result = 32'h1; cycle(1'b1, b, 1'b0, 1'b0, 1'b0, acc);
    b = rand_beat(); b.result = 32'h2; cycle(1'b1, b, 1'b0, 1'b0, 1'b0, acc);
    check("t2_full_ready", 128'(in_ready), 128'(0));
    b = rand_beat(); b.result = 32'h3; cycle(1'b1, b, 1'b0, 1'b0, 1'b0, acc);
    check("t2_c_held", 128'(acc), 128'(0));
    n = 0;
    do begin
      cycle(1'b1, b, 1'b1, 1'b0, 1'b0, acc);
      n++;
    end while (!acc && n < 10);
    check("t2_c_accepted", 128'(acc), 128'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0, acc);
    check("t2_delivered", 128'(delivered - d0), 128'(3));

    // Flush while full with a beat offered.
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, acc);
    b = rand_beat(); b.result = 32'h4;
    cycle(1'b1, b, 1'b1, 1'b1, 1'b0, acc);
    check("t3_valid", 128'(out_valid), 128'(0));
    check("t3_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0, acc);

    // Reset while full and stalled.
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, rand_beat(), 1'b0, 1'b1, 1'b1, acc);
    check_zero("t4_reset_full");

    // Stream 100 beats with a 50% MEM ready.
    n = 0; cyc = 0;
    while (n < 100 && cyc < 2000) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_beat(), 1'($urandom), 1'b0, 1'b0, acc);
      if (acc) n++;
      cyc++;
    end
    check("t5_streamed", 128'(n), 128'(100));

`ifdef EX_MEM_EXC_TRAP_EN
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0, acc);
    b = rand_beat(); b.overflow = 1; b.underflow = 0; b.reg_write = 1; b.pc = 32'h0040_0010;
    cycle(1'b1, b, 1'b1, 1'b0, 1'b0, acc);
    check("t6_reg_write", 128'(out_reg_write), 128'(0));
    check("t6_exc_valid", 128'(exc_valid), 128'(1));
    check("t6_exc_epc", 128'(exc_epc), 128'(32'h0040_0010));
    cycle(1'b0, rand_beat(), 1'b1, 1'b0, 1'b0, acc);
    check("t6_exc_pulse", 128'(exc_valid), 128'(0));
    check("t6_epc_held", 128'(exc_epc), 128'(32'h0040_0010));
`endif

    // Random mix including flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), rand_beat(), 1'($urandom),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 59) == 0), acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
